seed_scan_ctrl: RTL and testbench



---
 rtl/seed_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_seed_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seed_scan_ctrl.sv
// Seed-hit sequencer: loads database words into the hit datapath, walks every
// window position, and hands each hit to the ungapped-extension engine.
module seed_scan_ctrl #(
  parameter int DB_WIDTH         = 512,
  parameter int WINDOWS_PER_WORD = 246,
  parameter int COMPARE_LAT      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         db_total_words,
  input  logic [DB_WIDTH-1:0] db_data,
  input  logic                db_valid,
  output logic                db_ready,
  output logic [DB_WIDTH-1:0] hit_db_data,
  output logic                hit_load,
  output logic                hit_shift,
  output logic                hit_db_valid,
  output logic                hit_stop,
  input  logic                hit_in,
  input  logic                start_expand_in,
  input  logic [8:0]          location_q_in,
  output logic                ext_req,
  output logic [31:0]         ext_db_pos,
  output logic [8:0]          ext_q_loc,
  input  logic                ext_done,
  output logic                busy,
  output logic                done,
  output logic [31:0]         hit_count,
  output logic [3:0]          dbgState
);

  // Handshake: a database word transfers on any clk edge where db_valid and
  // db_ready are both high; db_ready is only ever high in LOAD.
  typedef enum logic [3:0] {
    IDLE, LOAD, SETTLE, CHECK, EXP_WAIT, EXT, STOP, SHIFT, DONE
  } stateT;

  localparam logic [31:0] LAST_WIN    = 32'(WINDOWS_PER_WORD - 1);
  localparam logic [31:0] WIN_PER_WRD = 32'(WINDOWS_PER_WORD);
  localparam logic [2:0]  SETTLE_LAST = 3'(COMPARE_LAT - 1);

  stateT       state, nextState;
  logic [31:0] totalWords;
  logic [31:0] wordIdx;
  logic [31:0] winIdx;
  logic [31:0] hitCount;
  logic [2:0]  settleCnt;
  logic [31:0] extDbPos;
  logic [8:0]  extQLoc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState    = state;
    db_ready     = 1'b0;
    hit_load     = 1'b0;
    hit_shift    = 1'b0;
    hit_db_valid = 1'b0;
    hit_stop     = 1'b0;
    ext_req      = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE:     if (start) nextState = (db_total_words == 32'd0) ? DONE : LOAD;
      LOAD: begin
        db_ready = 1'b1;
        hit_load = db_valid;
        if (db_valid) nextState = SETTLE;
      end
      SETTLE: begin
        hit_db_valid = 1'b1;
        if (settleCnt == SETTLE_LAST) nextState = CHECK;
      end
      CHECK: begin
        hit_db_valid = 1'b1;
        nextState    = hit_in ? EXP_WAIT : SHIFT;
      end
      EXP_WAIT: begin
        hit_db_valid = 1'b1;
        if (start_expand_in) nextState = EXT;
      end
      EXT: begin
        hit_db_valid = 1'b1;
        ext_req      = 1'b1;
        if (ext_done) nextState = STOP;
      end
      STOP: begin
        hit_db_valid = 1'b1;
        hit_stop     = 1'b1;
        nextState    = SHIFT;
      end
      SHIFT: begin
        hit_shift = 1'b1;
        if (winIdx == LAST_WIN)
          nextState = (wordIdx == totalWords - 32'd1) ? DONE : LOAD;
        else
          nextState = SETTLE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      totalWords <= '0;
      wordIdx    <= '0;
      winIdx     <= '0;
      hitCount   <= '0;
      settleCnt  <= '0;
      extDbPos   <= '0;
      extQLoc    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          totalWords <= db_total_words;
          wordIdx    <= '0;
          winIdx     <= '0;
          hitCount   <= '0;
        end
        LOAD: begin
          settleCnt <= '0;
          if (db_valid) winIdx <= '0;
        end
        SETTLE:   settleCnt <= (settleCnt == SETTLE_LAST) ? 3'd0 : settleCnt + 3'd1;
        EXP_WAIT: if (start_expand_in) begin
          // Position is the window's absolute base in the database, mod 2^32.
          extDbPos <= wordIdx * WIN_PER_WRD + winIdx;
          extQLoc  <= location_q_in;
        end
        EXT:      if (ext_done && hitCount != 32'hFFFF_FFFF) hitCount <= hitCount + 32'd1;
        SHIFT: begin
          settleCnt <= '0;
          if (winIdx == LAST_WIN) begin
            wordIdx <= wordIdx + 32'd1;
            winIdx  <= '0;
          end else begin
            winIdx <= winIdx + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hit_db_data = db_data;
  assign hit_count   = hitCount;
  assign ext_db_pos  = extDbPos;
  assign ext_q_loc   = extQLoc;
  assign dbgState    = state;

endmodule

// File: tb/tb_seed_scan_ctrl.sv
// Bench for seed_scan_ctrl: a reactive environment plays DMA, comparator and
// extension engine; a scenario-level model predicts hits, pulse counts and timing.
module tb_seed_scan_ctrl;
  localparam int DBW = 512;
  localparam int WPW = 246;
  localparam int LAT = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [31:0]    db_total_words;
  logic [DBW-1:0] db_data;
  logic           db_valid;
  logic           db_ready;
  logic [DBW-1:0] hit_db_data;
  logic           hit_load, hit_shift, hit_db_valid, hit_stop;
  logic           hit_in, start_expand_in;
  logic [8:0]     location_q_in;
  logic           ext_req;
  logic [31:0]    ext_db_pos;
  logic [8:0]     ext_q_loc;
  logic           ext_done;
  logic           busy, done;
  logic [31:0]    hit_count;
  logic [3:0]     dbgState;

  always #5 clk = ~clk;

  seed_scan_ctrl #(.DB_WIDTH(DBW), .WINDOWS_PER_WORD(WPW), .COMPARE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .db_total_words(db_total_words),
    .db_data(db_data), .db_valid(db_valid), .db_ready(db_ready),
    .hit_db_data(hit_db_data), .hit_load(hit_load), .hit_shift(hit_shift),
    .hit_db_valid(hit_db_valid), .hit_stop(hit_stop), .hit_in(hit_in),
    .start_expand_in(start_expand_in), .location_q_in(location_q_in),
    .ext_req(ext_req), .ext_db_pos(ext_db_pos), .ext_q_loc(ext_q_loc),
    .ext_done(ext_done), .busy(busy), .done(done), .hit_count(hit_count),
    .dbgState(dbgState)
  );

  int nCompared = 0;
  int nMismatch = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Scenario description: words to scan, LOAD stalls per word, and hit list.
  int nWords;
  int stallArr[8];
  int nHits;
  int hWord[4], hWin[4], hQ[4], hExtra[4], hLen[4];

  function automatic int hit_at(input int w, input int p);
    for (int i = 0; i < nHits; i++)
      if (hWord[i] == w && hWin[i] == p) return i;
    return -1;
  endfunction

  // Busy cycles preceding the done cycle, from per-word and per-hit costs.
  function automatic int expected_busy();
    int c = 0;
    for (int w = 0; w < nWords; w++) c += 1 + stallArr[w] + WPW * (LAT + 2);
    for (int h = 0; h < nHits; h++) c += (1 + hExtra[h]) + hLen[h] + 1;
    return c;
  endfunction

  task automatic clear_scenario(input int words);
    nWords = words;
    nHits  = 0;
    for (int i = 0; i < 8; i++) stallArr[i] = 0;
  endtask

  task automatic add_hit(input int w, input int p, input int q, input int extra, input int len);
    hWord[nHits] = w; hWin[nHits] = p; hQ[nHits] = q;
    hExtra[nHits] = extra; hLen[nHits] = len;
    nHits++;
  endtask

  task automatic run_scan(input bit abortOnExt, output int busyCyc);
    int loads = 0, shifts = 0, stops = 0;
    int curWord = -1, curWin = 0, posCnt = 0, extCnt = 0;
    int stallLeft, hlErr = 0, hi;
    bit sawDone = 0, aborted = 0;
    stallLeft = stallArr[0];
    busyCyc = 0;
    @(negedge clk);
    start = 1'b1;
    db_total_words = 32'(nWords);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      start = busy ? 1'($urandom_range(1)) : 1'b0;
      db_total_words = $urandom;
      if (done) begin
        start = 1'b0;
        sawDone = 1;
        check_eq("busy_in_done", busy, 1);
        break;
      end
      if (busy) busyCyc++;
      if (hit_shift) shifts++;
      if (hit_stop) stops++;
      if (hit_db_valid && !ext_req && !hit_stop) posCnt++;
      hi = (curWord >= 0) ? hit_at(curWord, curWin) : -1;
      hit_in = (hi >= 0);
      if (hi >= 0) begin
        start_expand_in = (posCnt >= LAT + 2 + hExtra[hi]);
        location_q_in   = 9'(hQ[hi]);
      end else begin
        start_expand_in = 1'($urandom_range(1));
        location_q_in   = 9'($urandom);
      end
      if (ext_req) begin
        extCnt++;
        if (hi < 0) begin
          check_eq("ext_req_at_hit_pos", 0, 1);
          ext_done = 1'b1;
        end else begin
          ext_done = (extCnt >= hLen[hi]);
          if (extCnt == 1 || ext_done) begin
            check_eq("ext_db_pos", ext_db_pos, 64'(32'(hWord[hi] * WPW + hWin[hi])));
            check_eq("ext_q_loc", ext_q_loc, 64'(hQ[hi]));
          end
        end
        if (abortOnExt && extCnt == 2) begin
          rst = 1'b1;
          @(negedge clk);
          check_eq("abort_ext_req", ext_req, 0);
          check_eq("abort_busy", busy, 0);
          check_eq("abort_hit_count", hit_count, 0);
          check_eq("abort_done", done, 0);
          rst = 1'b0;
          aborted = 1;
          break;
        end
      end else begin
        extCnt = 0;
        ext_done = 1'($urandom_range(1));
      end
      if (db_ready && stallLeft > 0) begin
        db_valid = 1'b0;
        stallLeft--;
      end else begin
        db_valid = 1'b1;
      end
      db_data = {16{$urandom}};
      #1;
      if (hit_load !== (db_ready && db_valid)) hlErr++;
      if (db_ready && db_valid) begin
        if (loads == 0) check_eq("hit_db_data_copy", 64'(hit_db_data == db_data), 1);
        curWord = loads;
        loads++;
        curWin = 0;
        posCnt = 0;
        stallLeft = (loads < 8) ? stallArr[loads] : 0;
      end
      if (hit_shift) begin
        curWin++;
        posCnt = 0;
      end
    end
    start = 1'b0;
    if (aborted) begin
      int lateDone = 0;
      busyCyc = -1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (done || busy) lateDone++;
      end
      check_eq("abort_no_done_after", lateDone, 0);
    end else begin
      check_eq("done_seen", sawDone, 1);
      check_eq("busy_cycles", busyCyc, expected_busy());
      check_eq("hit_load_pulses", loads, nWords);
      check_eq("hit_shift_pulses", shifts, nWords * WPW);
      check_eq("hit_stop_pulses", stops, nHits);
      check_eq("hit_count", hit_count, nHits);
      check_eq("hit_load_follows_valid", hlErr, 0);
      @(negedge clk);
      check_eq("done_one_cycle", done, 0);
      check_eq("idle_after_done", busy, 0);
      check_eq("hit_count_held", hit_count, nHits);
    end
  endtask

  initial begin
    int b0, b1, bz;
    rst = 1'b1; start = 1'b0; db_total_words = '0; db_data = '0; db_valid = 1'b0;
    hit_in = 1'b0; start_expand_in = 1'b0; location_q_in = '0; ext_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_db_ready", db_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_hit_load", hit_load, 0);
    check_eq("rst_hit_shift", hit_shift, 0);
    check_eq("rst_hit_stop", hit_stop, 0);
    check_eq("rst_hit_db_valid", hit_db_valid, 0);
    check_eq("rst_ext_req", ext_req, 0);
    check_eq("rst_ext_db_pos", ext_db_pos, 0);
    check_eq("rst_ext_q_loc", ext_q_loc, 0);
    check_eq("rst_hit_count", hit_count, 0);
    check_eq("rst_hit_db_data", 64'(hit_db_data == '0), 1);
    rst = 1'b0;

    // Zero-length scan: done arrives with no preceding busy cycle.
    clear_scenario(0);
    run_scan(0, bz);

    // Two hit-free words.
    clear_scenario(2);
    run_scan(0, b0);
    check_eq("two_word_busy_abs", b0, 1478);

    // Single hit at word 1, window 17.
    clear_scenario(2);
    add_hit(1, 17, 34, 0, 5);
    run_scan(0, b0);

    // Back-pressure: 10 stall cycles add exactly 10 cycles.
    clear_scenario(1);
    run_scan(0, b0);
    clear_scenario(1);
    stallArr[0] = 10;
    run_scan(0, b1);
    check_eq("backpressure_delta", b1 - b0, 10);

    // Randomized scans.
    for (int t = 0; t < 4; t++) begin
      clear_scenario($urandom_range(3, 1));
      for (int w = 0; w < nWords; w++) stallArr[w] = $urandom_range(5);
      for (int h = 0, n = $urandom_range(3); h < n; h++) begin
        int w, p;
        do begin
          w = $urandom_range(nWords - 1);
          p = $urandom_range(WPW - 1);
        end while (hit_at(w, p) >= 0);
        add_hit(w, p, $urandom_range(511), $urandom_range(3), $urandom_range(6, 1));
      end
      run_scan(0, b0);
    end

    // Reset during an extension, then a normal scan.
    clear_scenario(1);
    add_hit(0, 100, 7, 1, 4);
    run_scan(1, b0);
    clear_scenario(1);
    add_hit(0, WPW - 1, 511, 2, 3);
    run_scan(0, b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
